// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory interface: one request at a time,
// 64-bit word array, read-modify-write for sub-dword stores, extended load data.
module data_mem_responder #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, WRITE, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [63:0]   mem [DEPTH];

   logic          a_we, a_uns;
   logic [1:0]    a_size;
   logic [AW-1:0] a_idx;
   logic [2:0]    a_lane;
   logic [63:0]   a_wdata;
   logic [63:0]   rd_word;

   logic          accept, req_bad;
   logic [2:0]    align_mask;
   logic [63:0]   mem_rd, shifted, load_ext, lane_mask, merged;
   logic [5:0]    sh;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   always_comb begin
      align_mask = '0;
      case (req_size)
         2'd0: align_mask = 3'b000;
         2'd1: align_mask = 3'b001;
         2'd2: align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   end

   // Any address bit above the word-index field set means out of range.
   assign req_bad = (|(req_addr[2:0] & align_mask)) || ((req_addr >> (AW + 3)) != 64'd0);

   assign sh       = {a_lane, 3'b000};
   assign mem_rd   = mem[a_idx];
   assign shifted  = mem_rd >> sh;

   always_comb begin
      load_ext  = shifted;
      lane_mask = '1;
      case (a_size)
         2'd0: begin
            load_ext  = a_uns ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            lane_mask = 64'h0000_0000_0000_00FF;
         end
         2'd1: begin
            load_ext  = a_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            lane_mask = 64'h0000_0000_0000_FFFF;
         end
         2'd2: begin
            load_ext  = a_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            lane_mask = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            load_ext  = shifted;
            lane_mask = '1;
         end
      endcase
   end

   assign merged = (rd_word & ~(lane_mask << sh)) | ((a_wdata << sh) & (lane_mask << sh));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = req_bad ? RESP : WAIT;
         WAIT:  if (cnt == '0) state_nxt = a_we ? WRITE : RESP;
         WRITE: state_nxt = RESP;
         RESP:  if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         a_we      <= 1'b0;
         a_uns     <= 1'b0;
         a_size    <= '0;
         a_idx     <= '0;
         a_lane    <= '0;
         a_wdata   <= '0;
         rd_word   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_we    <= req_we;
               a_uns   <= req_unsigned;
               a_size  <= req_size;
               a_idx   <= req_addr[3 +: AW];
               a_lane  <= req_addr[2:0];
               a_wdata <= req_wdata;
               cnt     <= CNT_INIT;
               if (req_bad) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (a_we) begin
                     rd_word <= mem_rd;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= load_ext;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WRITE: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: ;
         endcase
      end
   end

   // Array is never reset; async reset forces state out of WRITE, aborting a pending write.
   always_ff @(posedge clk) begin
      if (state == WRITE) mem[a_idx] <= merged;
   end

endmodule
